// File: rtl/spike_wave_scheduler.sv
// Sequences one temporal-coded wave through the spike_generation bank:
// accept a wave, sweep time_val over TIME_PERIOD ticks, idle a gamma gap, then hand off.
`ifndef TIME_PERIOD_DFLT
`define TIME_PERIOD_DFLT 8
`endif

module spike_wave_scheduler #(
  parameter int NUM_INPUTS  = 8,
  parameter int TIME_PERIOD = `TIME_PERIOD_DFLT,
  parameter int TW          = $clog2(TIME_PERIOD),
  parameter int GAP_CYCLES  = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_INPUTS*TW-1:0]          in_spike_time,
  input  logic [NUM_INPUTS-1:0]             in_enable,
  input  logic                              step_en,
  output logic [TW-1:0]                     gen_time_val,
  output logic [NUM_INPUTS*TW-1:0]          gen_spike_time,
  output logic [NUM_INPUTS-1:0]             gen_should_spike,
  output logic [NUM_INPUTS-1:0]             spike_out,
  output logic [$clog2(NUM_INPUTS+1)-1:0]   spike_count,
  output logic                              wave_active,
  output logic                              wave_done,
  input  logic                              done_ack
);

  localparam int CW = $clog2(NUM_INPUTS + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

  // Handshakes: a wave transfers on a clock where in_valid && in_ready;
  // a completion transfers on a clock where wave_done && done_ack.
  state_t                    state_q, state_d;
  logic [TW-1:0]             tv_q, tv_d;
  logic [NUM_INPUTS*TW-1:0]  times_q, times_d;
  logic [NUM_INPUTS-1:0]     mask_q, mask_d;
  logic [NUM_INPUTS-1:0]     spike_q, spike_d;
  logic [CW-1:0]             count_q, count_d;
  logic [GW-1:0]             gap_q, gap_d;
  logic [NUM_INPUTS-1:0]     hit;
  logic [CW:0]               hit_cnt;
  logic [CW:0]               sum;

  always_comb begin
    state_d = state_q;
    tv_d    = tv_q;
    times_d = times_q;
    mask_d  = mask_q;
    spike_d = '0;
    count_d = count_q;
    gap_d   = gap_q;
    hit     = '0;
    hit_cnt = '0;
    sum     = '0;

    // tv_q never reaches TIME_PERIOD, so out-of-range spike times cannot match.
    for (int i = 0; i < NUM_INPUTS; i++) begin
      hit[i]  = mask_q[i] && (times_q[i*TW +: TW] == tv_q);
      hit_cnt = hit_cnt + (CW+1)'(hit[i]);
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          times_d = in_spike_time;
          mask_d  = in_enable;
          tv_d    = '0;
          count_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (step_en) begin
          spike_d = hit;
          sum     = (CW+1)'(count_q) + hit_cnt;
          count_d = (sum > (CW+1)'(NUM_INPUTS)) ? CW'(NUM_INPUTS) : sum[CW-1:0];
          if (tv_q == TW'(TIME_PERIOD - 1)) begin
            state_d = S_GAP;
            gap_d   = '0;
          end else begin
            tv_d = tv_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        tv_d = '0;
        if (gap_q == GW'(GAP_CYCLES - 1)) state_d = S_DONE;
        else                              gap_d   = gap_q + 1'b1;
      end
      S_DONE: begin
        if (done_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tv_q    <= '0;
      times_q <= '0;
      mask_q  <= '0;
      spike_q <= '0;
      count_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      tv_q    <= tv_d;
      times_q <= times_d;
      mask_q  <= mask_d;
      spike_q <= spike_d;
      count_q <= count_d;
      gap_q   <= gap_d;
    end
  end

  assign in_ready         = (state_q == S_IDLE);
  assign wave_active      = (state_q == S_RUN);
  assign wave_done        = (state_q == S_DONE);
  assign gen_should_spike = wave_active ? mask_q : '0;
  assign gen_time_val     = tv_q;
  assign gen_spike_time   = times_q;
  assign spike_out        = spike_q;
  assign spike_count      = count_q;

endmodule

// File: tb/tb_spike_wave_scheduler.sv
// Directed bench for spike_wave_scheduler: TIME_PERIOD=8 main instance plus a
// TIME_PERIOD=6 instance for out-of-range spike times.
module tb_spike_wave_scheduler;

  localparam logic [23:0] RAMP  = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [23:0] ALL3  = {8{3'd3}};
  localparam logic [23:0] ALL0  = {8{3'd0}};
  localparam logic [23:0] ALL5  = {8{3'd5}};
  localparam logic [23:0] ALL7  = {8{3'd7}};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, step_en, wave_active, wave_done, done_ack;
  logic [23:0] in_spike_time, gen_spike_time;
  logic [7:0]  in_enable, gen_should_spike, spike_out;
  logic [2:0]  gen_time_val;
  logic [3:0]  spike_count;

  logic        b_in_valid, b_in_ready, b_wave_active, b_wave_done, b_done_ack;
  logic [23:0] b_in_spike_time, b_gen_spike_time;
  logic [7:0]  b_in_enable, b_gen_should_spike, b_spike_out;
  logic [2:0]  b_gen_time_val;
  logic [3:0]  b_spike_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spike_wave_scheduler #(.NUM_INPUTS(8), .TIME_PERIOD(8), .GAP_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_spike_time(in_spike_time), .in_enable(in_enable), .step_en(step_en),
    .gen_time_val(gen_time_val), .gen_spike_time(gen_spike_time),
    .gen_should_spike(gen_should_spike), .spike_out(spike_out),
    .spike_count(spike_count), .wave_active(wave_active), .wave_done(wave_done),
    .done_ack(done_ack)
  );

  spike_wave_scheduler #(.NUM_INPUTS(8), .TIME_PERIOD(6), .GAP_CYCLES(2)) u_dut6 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_spike_time(b_in_spike_time), .in_enable(b_in_enable), .step_en(1'b1),
    .gen_time_val(b_gen_time_val), .gen_spike_time(b_gen_spike_time),
    .gen_should_spike(b_gen_should_spike), .spike_out(b_spike_out),
    .spike_count(b_spike_count), .wave_active(b_wave_active), .wave_done(b_wave_done),
    .done_ack(b_done_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [23:0] times, input logic [7:0] en);
    in_spike_time = times;
    in_enable     = en;
    in_valid      = 1'b1;
    tick();
    in_valid      = 1'b0;
    check("run_entry_active", 32'(wave_active), 32'd1);
    check("run_entry_tv", 32'(gen_time_val), 32'd0);
  endtask

  // Eight back-to-back ticks; exp holds the expected spike_out after step k at [k*8 +: 8].
  task automatic run8(input logic [7:0] en, input logic [63:0] exp);
    for (int k = 0; k < 8; k++) begin
      check("run_tv", 32'(gen_time_val), 32'(k));
      check("run_should_spike", 32'(gen_should_spike), 32'(en));
      tick();
      check("run_spike_out", 32'(spike_out), 32'(exp[k*8 +: 8]));
    end
    check("gap_active", 32'(wave_active), 32'd0);
    check("gap_should_spike", 32'(gen_should_spike), 32'd0);
    check("gap_tv_held", 32'(gen_time_val), 32'd7);
  endtask

  task automatic finish_wave(input logic [3:0] exp_count);
    tick();
    check("gap2_tv_zero", 32'(gen_time_val), 32'd0);
    check("gap2_not_done", 32'(wave_done), 32'd0);
    check("gap2_spike_out", 32'(spike_out), 32'd0);
    tick();
    check("done_flag", 32'(wave_done), 32'd1);
    check("done_count", 32'(spike_count), 32'(exp_count));
    check("done_ready", 32'(in_ready), 32'd0);
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    check("ack_ready", 32'(in_ready), 32'd1);
    check("ack_done_clr", 32'(wave_done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; step_en = 1'b1; done_ack = 1'b0;
    in_spike_time = '0; in_enable = '0;
    b_in_valid = 1'b0; b_done_ack = 1'b0; b_in_spike_time = '0; b_in_enable = '0;
    tick();
    tick();
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_active", 32'(wave_active), 32'd0);
    check("rst_done", 32'(wave_done), 32'd0);
    check("rst_spike", 32'(spike_out), 32'd0);
    check("rst_tv", 32'(gen_time_val), 32'd0);
    check("rst_count", 32'(spike_count), 32'd0);
    check("rst_gst", 32'(gen_spike_time), 32'd0);
    check("rst_gss", 32'(gen_should_spike), 32'd0);
    rst = 1'b0;
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    check("idle_ack_ignored", 32'(in_ready), 32'd1);

    // Ramp of times, all enabled: one-hot walks bit0..bit7.
    accept(RAMP, 8'hFF);
    check("ramp_gst", 32'(gen_spike_time), 32'(RAMP));
    run8(8'hFF, 64'h8040201008040201);
    finish_wave(4'd8);

    // Same time on every line, sparse mask: one pulse of 8'hA5 after step 3.
    accept(ALL3, 8'hA5);
    run8(8'hA5, 64'h00000000A5000000);
    finish_wave(4'd4);

    // Nothing enabled: no pulses, count 0, completion still reported.
    accept(RAMP, 8'h00);
    run8(8'h00, 64'h0);
    finish_wave(4'd0);

    // step_en pattern 1,0,0 repeating: 8 ticks over 22 RUN cycles.
    accept(RAMP, 8'hFF);
    for (int c = 0; c < 22; c++) begin
      step_en = (c % 3 == 0);
      check("gated_active", 32'(wave_active), 32'd1);
      check("gated_tv", 32'(gen_time_val), 32'((c + 2) / 3));
      tick();
      check("gated_spike", 32'(spike_out), (c % 3 == 0) ? (32'd1 << (c / 3)) : 32'd0);
    end
    check("gated_end_active", 32'(wave_active), 32'd0);
    step_en = 1'b0;
    finish_wave(4'd8);
    step_en = 1'b1;

    // in_valid held high across a wave; wave_done held 5 clocks without ack.
    in_spike_time = ALL0;
    in_enable     = 8'h0F;
    in_valid      = 1'b1;
    tick();
    check("hold_first_spike", 32'(spike_out), 32'd0);
    for (int c = 0; c < 10; c++) begin
      check("hold_not_ready", 32'(in_ready), 32'd0);
      if (c == 0) check("hold_tv0", 32'(gen_time_val), 32'd0);
      tick();
      if (c == 0) check("hold_spike0", 32'(spike_out), 32'h0F);
    end
    for (int k = 0; k < 5; k++) begin
      check("hold_done", 32'(wave_done), 32'd1);
      check("hold_done_not_ready", 32'(in_ready), 32'd0);
      if (k == 4) begin
        in_spike_time = RAMP;
        in_enable     = 8'hFF;
        done_ack      = 1'b1;
      end
      tick();
    end
    done_ack = 1'b0;
    check("hold_idle_ready", 32'(in_ready), 32'd1);
    check("hold_count_kept", 32'(spike_count), 32'd4);
    tick();
    in_valid = 1'b0;
    check("second_accept_active", 32'(wave_active), 32'd1);
    check("second_accept_count", 32'(spike_count), 32'd0);
    tick(); tick(); tick(); tick();
    check("pre_rst_tv", 32'(gen_time_val), 32'd4);
    check("pre_rst_spike", 32'(spike_out), 32'h08);

    // Reset mid-wave at time_val 4.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_active", 32'(wave_active), 32'd0);
    check("midrst_done", 32'(wave_done), 32'd0);
    check("midrst_spike", 32'(spike_out), 32'd0);
    check("midrst_tv", 32'(gen_time_val), 32'd0);
    check("midrst_count", 32'(spike_count), 32'd0);
    check("midrst_gss", 32'(gen_should_spike), 32'd0);
    check("midrst_gst", 32'(gen_spike_time), 32'd0);
    accept(ALL5, 8'h81);
    run8(8'h81, 64'h0000810000000000);
    finish_wave(4'd2);

    // TIME_PERIOD=6 instance: times of 7 never fire but are passed through.
    b_in_spike_time = ALL7;
    b_in_enable     = 8'hFF;
    b_in_valid      = 1'b1;
    tick();
    b_in_valid = 1'b0;
    check("tp6_gst", 32'(b_gen_spike_time), 32'(ALL7));
    check("tp6_active", 32'(b_wave_active), 32'd1);
    for (int c = 0; c < 8; c++) begin
      check("tp6_not_done", 32'(b_wave_done), 32'd0);
      tick();
      check("tp6_spike", 32'(b_spike_out), 32'd0);
    end
    check("tp6_done", 32'(b_wave_done), 32'd1);
    check("tp6_count", 32'(b_spike_count), 32'd0);
    b_done_ack = 1'b1;
    tick();
    b_done_ack = 1'b0;
    check("tp6_ready", 32'(b_in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
